// File: rtl/ps2_command_out.sv
// PS/2 host-to-device command transmitter: requests to send, shifts out a byte with odd parity,
// and checks the device acknowledge under two timeout windows.
module ps2_command_out #(
    parameter int CLOCK_CYCLES_101US = 5050,
    parameter int TIMEOUT_15MS       = 750000,
    parameter int TIMEOUT_2MS        = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    input  logic       ps2_clk_posedge,
    input  logic       ps2_clk_negedge,
    input  logic       ps2_data,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low,
    output logic       command_was_sent,
    output logic       error_communication_timed_out,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_INITIATE       = 3'd1,
        S_WAIT_FOR_CLOCK = 3'd2,
        S_TX_BITS        = 3'd3,
        S_TX_STOP        = 3'd4,
        S_WAIT_ACK       = 3'd5,
        S_COMPLETE       = 3'd6,
        S_ERROR          = 3'd7
    } state_e;

    localparam logic [19:0] INIT_LAST = 20'(CLOCK_CYCLES_101US - 1);
    localparam logic [19:0] T15_LAST  = 20'(TIMEOUT_15MS - 1);
    localparam logic [19:0] T2_LAST   = 20'(TIMEOUT_2MS - 1);

    state_e      state_q, state_d;
    logic [19:0] timer_q, timer_d;
    logic [3:0]  bit_count_q, bit_count_d;
    logic [8:0]  shift_q, shift_d;
    logic        clk_low_q, clk_low_d;
    logic        dat_low_q, dat_low_d;
    logic        sent_q, sent_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_count_d = bit_count_q;
        shift_d     = shift_q;

        case (state_q)
            S_IDLE: begin
                if (send_command) begin
                    shift_d     = {~^the_command, the_command};
                    bit_count_d = 4'd0;
                    timer_d     = 20'd0;
                    state_d     = S_INITIATE;
                end
            end
            S_INITIATE: begin
                if (timer_q == INIT_LAST) begin
                    timer_d = 20'd0;
                    state_d = S_WAIT_FOR_CLOCK;
                end else begin
                    timer_d = timer_q + 20'd1;
                end
            end
            S_WAIT_FOR_CLOCK: begin
                timer_d = timer_q + 20'd1;
                if (ps2_clk_negedge) begin
                    timer_d = 20'd0;
                    state_d = S_TX_BITS;
                end else if (timer_q >= T15_LAST) begin
                    state_d = S_ERROR;
                end
            end
            // The 2 ms window spans the whole frame, so the timer keeps running through these states.
            S_TX_BITS: begin
                timer_d = timer_q + 20'd1;
                if (ps2_clk_negedge) begin
                    if (bit_count_q == 4'd8) begin
                        state_d = S_TX_STOP;
                    end else begin
                        shift_d     = {1'b0, shift_q[8:1]};
                        bit_count_d = bit_count_q + 4'd1;
                    end
                end else if (timer_q >= T2_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_TX_STOP: begin
                timer_d = timer_q + 20'd1;
                if (ps2_clk_negedge) begin
                    state_d = S_WAIT_ACK;
                end else if (timer_q >= T2_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_WAIT_ACK: begin
                timer_d = timer_q + 20'd1;
                if (ps2_clk_posedge) begin
                    state_d = ps2_data ? S_ERROR : S_COMPLETE;
                end else if (timer_q >= T2_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_COMPLETE, S_ERROR: begin
                if (!send_command) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copy tracks the state register exactly.
    always_comb begin
        clk_low_d = (state_d == S_INITIATE);
        dat_low_d = (state_d == S_WAIT_FOR_CLOCK) || ((state_d == S_TX_BITS) && !shift_d[0]);
        sent_d    = (state_d == S_COMPLETE);
        err_d     = (state_d == S_ERROR);
        busy_d    = (state_d != S_IDLE);
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            timer_q     <= 20'd0;
            bit_count_q <= 4'd0;
            shift_q     <= 9'd0;
            clk_low_q   <= 1'b0;
            dat_low_q   <= 1'b0;
            sent_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_count_q <= bit_count_d;
            shift_q     <= shift_d;
            clk_low_q   <= clk_low_d;
            dat_low_q   <= dat_low_d;
            sent_q      <= sent_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign ps2_clk_drive_low             = clk_low_q;
    assign ps2_dat_drive_low             = dat_low_q;
    assign command_was_sent              = sent_q;
    assign error_communication_timed_out = err_q;
    assign busy                          = busy_q;

endmodule

// File: tb/tb_ps2_command_out.sv
// Directed bench for ps2_command_out: a small device model clocks frames and checks
// hold time, frame bits, acknowledge handling, both timeouts and asynchronous reset.
module tb_ps2_command_out;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] the_command = 8'h00;
    logic       send_command = 1'b0;
    logic       ps2_clk_posedge = 1'b0;
    logic       ps2_clk_negedge = 1'b0;
    logic       ps2_data = 1'b1;
    logic       ps2_clk_drive_low;
    logic       ps2_dat_drive_low;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    ps2_command_out #(
        .CLOCK_CYCLES_101US(10),
        .TIMEOUT_15MS(200),
        .TIMEOUT_2MS(500)
    ) dut (
        .clk(clk),
        .reset(reset),
        .the_command(the_command),
        .send_command(send_command),
        .ps2_clk_posedge(ps2_clk_posedge),
        .ps2_clk_negedge(ps2_clk_negedge),
        .ps2_data(ps2_data),
        .ps2_clk_drive_low(ps2_clk_drive_low),
        .ps2_dat_drive_low(ps2_dat_drive_low),
        .command_was_sent(command_was_sent),
        .error_communication_timed_out(error_communication_timed_out),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Raise send_command and count the cycles the PS/2 clock is held low.
    task automatic start_send(input logic [7:0] cmd, output int low_cycles);
        low_cycles = 0;
        @(negedge clk);
        the_command  = cmd;
        send_command = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ps2_clk_drive_low) low_cycles++;
            else break;
        end
    endtask

    // Device clock cycles: line level sampled at each posedge, then a falling edge.
    task automatic device_clock(input int first, input int last, inout logic [10:0] bits,
                                output int first_neg_cyc);
        first_neg_cyc = 0;
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            bits[i] = ~ps2_dat_drive_low;
            ps2_clk_posedge = 1'b1;
            @(negedge clk);
            ps2_clk_posedge = 1'b0;
            @(negedge clk);
            ps2_clk_negedge = 1'b1;
            if (i == first) first_neg_cyc = cyc + 1;
            @(negedge clk);
            ps2_clk_negedge = 1'b0;
        end
    endtask

    task automatic device_ack(input logic level);
        @(negedge clk);
        ps2_data        = level;
        ps2_clk_posedge = 1'b1;
        @(negedge clk);
        ps2_clk_posedge = 1'b0;
        ps2_data        = 1'b1;
    endtask

    task automatic release_and_check_idle(input string name);
        send_command = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || command_was_sent !== 1'b0 || error_communication_timed_out !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle: busy=%b sent=%b err=%b, required 0 0 0", name, busy,
                     command_was_sent, error_communication_timed_out);
        end
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({ps2_clk_drive_low, ps2_dat_drive_low, command_was_sent,
             error_communication_timed_out, busy} !== 5'b0) begin
            n_err++;
            $display("FAIL reset outputs: got %b%b%b%b%b, required 00000", ps2_clk_drive_low,
                     ps2_dat_drive_low, command_was_sent, error_communication_timed_out, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle after reset: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_send_ed();
        int low;
        int fn;
        logic [10:0] bits = '0;
        start_send(8'hED, low);
        n_vec++;
        if (low !== 10) begin
            n_err++;
            $display("FAIL ed clock hold: got %0d cycles, required 10", low);
        end
        n_vec++;
        if (ps2_dat_drive_low !== 1'b1 || ps2_clk_drive_low !== 1'b0) begin
            n_err++;
            $display("FAIL ed start bit: dat_low=%b clk_low=%b, required 1 0", ps2_dat_drive_low,
                     ps2_clk_drive_low);
        end
        device_clock(0, 10, bits, fn);
        n_vec++;
        if (bits !== 11'h7DA) begin
            n_err++;
            $display("FAIL ed frame: got %b, required %b", bits, 11'h7DA);
        end
        device_ack(1'b0);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (command_was_sent !== 1'b1 || busy !== 1'b1 || ps2_dat_drive_low !== 1'b0) begin
                n_err++;
                $display("FAIL ed complete hold %0d: sent=%b busy=%b dat_low=%b, required 1 1 0", i,
                         command_was_sent, busy, ps2_dat_drive_low);
            end
            @(negedge clk);
        end
        release_and_check_idle("ed");
    endtask

    // send_command drops and the_command changes mid-transfer; neither may disturb the frame.
    task automatic test_send_f4_ignore();
        int low;
        int fn;
        logic [10:0] bits = '0;
        start_send(8'hF4, low);
        device_clock(0, 3, bits, fn);
        the_command  = 8'h00;
        send_command = 1'b0;
        device_clock(4, 10, bits, fn);
        n_vec++;
        if (bits !== 11'h5E8) begin
            n_err++;
            $display("FAIL f4 frame: got %b, required %b", bits, 11'h5E8);
        end
        send_command = 1'b1;
        device_ack(1'b0);
        n_vec++;
        if (command_was_sent !== 1'b1 || error_communication_timed_out !== 1'b0) begin
            n_err++;
            $display("FAIL f4 complete: sent=%b err=%b, required 1 0", command_was_sent,
                     error_communication_timed_out);
        end
        release_and_check_idle("f4");
    endtask

    task automatic test_timeout_no_clock();
        int low;
        int entry;
        int waited = 0;
        start_send(8'h55, low);
        entry = cyc;
        while (!error_communication_timed_out && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (cyc - entry !== 200) begin
            n_err++;
            $display("FAIL wait-clock timeout: error after %0d cycles, required 200", cyc - entry);
        end
        n_vec++;
        if (ps2_clk_drive_low !== 1'b0 || ps2_dat_drive_low !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL timeout lines: clk_low=%b dat_low=%b busy=%b, required 0 0 1",
                     ps2_clk_drive_low, ps2_dat_drive_low, busy);
        end
        release_and_check_idle("timeout");
    endtask

    task automatic test_nack();
        int low;
        int fn;
        logic [10:0] bits = '0;
        start_send(8'hA5, low);
        device_clock(0, 10, bits, fn);
        device_ack(1'b1);
        n_vec++;
        if (error_communication_timed_out !== 1'b1 || command_was_sent !== 1'b0) begin
            n_err++;
            $display("FAIL nack: err=%b sent=%b, required 1 0", error_communication_timed_out,
                     command_was_sent);
        end
        release_and_check_idle("nack");
    endtask

    task automatic test_stall();
        int low;
        int first_neg;
        int waited = 0;
        logic [10:0] bits = '0;
        start_send(8'h3C, low);
        device_clock(0, 3, bits, first_neg);
        while (!error_communication_timed_out && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (cyc - first_neg !== 500) begin
            n_err++;
            $display("FAIL frame timeout: error after %0d cycles, required 500", cyc - first_neg);
        end
        release_and_check_idle("stall");
    endtask

    task automatic test_reset_mid_frame();
        int low;
        int fn;
        logic [10:0] bits = '0;
        start_send(8'h3C, low);
        device_clock(0, 4, bits, fn);
        @(negedge clk);
        #2;
        reset        = 1'b0;
        send_command = 1'b0;
        #1;
        n_vec++;
        if ({ps2_clk_drive_low, ps2_dat_drive_low, command_was_sent,
             error_communication_timed_out, busy} !== 5'b0) begin
            n_err++;
            $display("FAIL async reset: got %b%b%b%b%b, required 00000", ps2_clk_drive_low,
                     ps2_dat_drive_low, command_was_sent, error_communication_timed_out, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        bits  = '0;
        start_send(8'h3C, low);
        device_clock(0, 10, bits, fn);
        n_vec++;
        if (bits !== 11'h678) begin
            n_err++;
            $display("FAIL post-reset frame: got %b, required %b", bits, 11'h678);
        end
        device_ack(1'b0);
        n_vec++;
        if (command_was_sent !== 1'b1) begin
            n_err++;
            $display("FAIL post-reset complete: sent=%b, required 1", command_was_sent);
        end
        release_and_check_idle("post-reset");
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_send_f4_ignore();
        test_timeout_no_clock();
        test_nack();
        test_stall();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
